// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic library's multi-cycle blocks.
package arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ser_sub_state_t;

    // Counter width for K chunks; at least one bit so K == 1 still elaborates.
    function automatic int unsigned ser_cnt_width(int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational W-bit ripple-borrow subtractor: d = x - y - bin, bout = final borrow.
module chunk_subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic borrow;

    always_comb begin
        // NOTE: blocking assignments here let the borrow ripple bit by bit within one evaluation;
        // assigning every output a default first guarantees no latch is inferred.
        d      = '0;
        borrow = bin;
        for (int i = 0; i < W; i++) begin
            d[i]   = x[i] ^ y[i] ^ borrow;
            borrow = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow);
        end
        bout = borrow;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: diff = a - b - bin, W bits per cycle, LSB chunk first,
// behind a valid/ready handshake on both sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int K  = N / W;
    localparam int CW = int'(ser_cnt_width(K));

    if (N % W != 0) begin : g_bad_width
        $error("serial_subtractor: N must be a multiple of W");
    end

    ser_sub_state_t state;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           borrow_q;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   chunk_d;
    logic           chunk_bout;
    logic [N-1:0]   diff_next;
    logic           last;

    chunk_subtractor #(.W(W)) u_chunk (
        .x    (a_q[cnt*W +: W]),
        .y    (b_q[cnt*W +: W]),
        .bin  (borrow_q),
        .d    (chunk_d),
        .bout (chunk_bout)
    );

    // Full-width result as it will look after this cycle's chunk lands; the flags need it on the last chunk.
    always_comb begin
        diff_next                = diff;
        diff_next[cnt*W +: W]    = chunk_d;
    end

    assign last      = (cnt == CW'(K - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff     <= diff_next;
                    borrow_q <= chunk_bout;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        bout  <= chunk_bout;
                        ovf   <= (a_q[N-1] != b_q[N-1]) && (diff_next[N-1] != a_q[N-1]);
                        zero  <= (diff_next == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=32, W=8): directed vectors with hand-computed results.
module tb_serial_subtractor;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } result_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;
    result_t sb[$];

    serial_subtractor #(.N(32), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on a cycle where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                check("diff", diff, e.diff);
                check("bout", 32'(bout), 32'(e.bout));
                check("ovf",  32'(ovf),  32'(e.ovf));
                check("zero", 32'(zero), 32'(e.zero));
            end
        end
    end

    // Issue one operation; returns after out_valid is first seen, reporting the latency in edges.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                         input logic push, input result_t exp, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        bin      = tbin;
        in_valid = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                          input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
        int lat;
        issue(ta, tb_, tbin, 1'b1, '{diff: ed, bout: eb, ovf: eo, zero: ez}, lat);
        check("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff",      diff,           32'd0);
        check("reset_flags",     {29'd0, bout, ovf, zero}, 32'd0);
        @(posedge clk); #1;

        // Basic, cross-chunk borrow, underflow, signed overflow, zero via bin.
        run_op(32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_0100,  32'h0000_0001,  1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_0000,  32'h0000_0001,  1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000_0000,  32'h0000_0001,  1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        run_op(32'h1234_5678,  32'h1234_5677,  1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        // Backpressure: hold the result while new operands are offered.
        out_ready = 1'b0;
        issue(32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 1'b1,
              '{diff: 32'h9696_9695, bout: 1'b0, ovf: 1'b0, zero: 1'b0}, lat);
        check("stall_latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0000;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_diff",      diff,           32'h9696_9695);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_stall", {30'd0, in_ready, out_valid}, 32'd2);
            @(posedge clk); #1;
        end
        run_op(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle aborts the operation.
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_diff",      diff,           32'd0);
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("no_stale_result", 32'(seen), 32'd0);
        end
        @(posedge clk); #1;
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
